// File: rtl/cache_wb_buffer_pkg.sv
// Shared LC-3b cache types and default geometry for the write-back buffer.
package cache_wb_buffer_pkg;

   localparam int unsigned LC3B_WORD_W   = 16;
   localparam int unsigned LC3B_LINE_W   = 128;
   localparam int unsigned LC3B_OFFSET_W = 4;

   typedef logic [LC3B_WORD_W-1:0]                 lc3b_word;
   typedef logic [LC3B_LINE_W-1:0]                 lc3b_c_line;
   typedef logic [LC3B_WORD_W-LC3B_OFFSET_W-1:0]   lc3b_c_line_addr;

   // Line address of a byte address (offset bits dropped).
   function automatic lc3b_c_line_addr line_addr(input lc3b_word byte_addr);
      return byte_addr[LC3B_WORD_W-1:LC3B_OFFSET_W];
   endfunction

endpackage

// File: rtl/cache_wb_entry.sv
// Single victim-line holding register: valid, line tag and data, with tag match.
module cache_wb_entry
   import cache_wb_buffer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = LC3B_WORD_W,
   parameter int unsigned LINE_WIDTH  = LC3B_LINE_W,
   parameter int unsigned OFFSET_BITS = LC3B_OFFSET_W
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              load,
   input  logic                              clear,
   input  logic [ADDR_WIDTH-OFFSET_BITS-1:0] load_tag,
   input  logic [LINE_WIDTH-1:0]             load_data,
   input  logic [ADDR_WIDTH-OFFSET_BITS-1:0] cmp_tag,
   output logic                              valid,
   output logic [ADDR_WIDTH-1:0]             addr,
   output logic [LINE_WIDTH-1:0]             data,
   output logic                              match
);

   localparam int unsigned TagWidth = ADDR_WIDTH - OFFSET_BITS;

   logic                  valid_q;
   logic [TagWidth-1:0]   tag_q;
   logic [LINE_WIDTH-1:0] data_q;

   // Load wins over clear; the FSM never asserts both in one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         tag_q   <= '0;
         data_q  <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         tag_q   <= load_tag;
         data_q  <= load_data;
      end else if (clear) begin
         valid_q <= 1'b0;
      end
   end

   always_comb begin
      valid = valid_q;
      addr  = {tag_q, {OFFSET_BITS{1'b0}}};
      data  = data_q;
      match = valid_q && (tag_q == cmp_tag);
   end

endmodule

// File: rtl/cache_wb_buffer.sv
// Single-entry victim buffer between L1 cache and pmem; evictions are absorbed, drained when idle.
// Define CACHE_WB_READ_FORWARD_EN to serve reads that hit the held line directly from the entry.
module cache_wb_buffer
   import cache_wb_buffer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = LC3B_WORD_W,
   parameter int unsigned LINE_WIDTH  = LC3B_LINE_W,
   parameter int unsigned OFFSET_BITS = LC3B_OFFSET_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cache_read,
   input  logic                  cache_write,
   input  logic [ADDR_WIDTH-1:0] cache_address,
   input  logic [LINE_WIDTH-1:0] cache_wdata,
   output logic [LINE_WIDTH-1:0] cache_rdata,
   output logic                  cache_resp,
   output logic                  pmem_read,
   output logic                  pmem_write,
   output logic [ADDR_WIDTH-1:0] pmem_address,
   output logic [LINE_WIDTH-1:0] pmem_wdata,
   input  logic [LINE_WIDTH-1:0] pmem_rdata,
   input  logic                  pmem_resp
);

   localparam int unsigned TagWidth = ADDR_WIDTH - OFFSET_BITS;

   typedef enum logic [1:0] {S_IDLE, S_RESP, S_READ, S_DRAIN} state_t;

   state_t                state_q, state_d;
   logic [LINE_WIDTH-1:0] rdata_q, rdata_d;

   logic                  entry_load;
   logic                  entry_clear;
   logic                  entry_valid;
   logic                  entry_match;
   logic [ADDR_WIDTH-1:0] entry_addr;
   logic [LINE_WIDTH-1:0] entry_data;
   logic [TagWidth-1:0]   req_tag;
   logic                  unused_offset;

   assign req_tag       = cache_address[ADDR_WIDTH-1:OFFSET_BITS];
   assign unused_offset = ^cache_address[OFFSET_BITS-1:0];

   cache_wb_entry #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .LINE_WIDTH  (LINE_WIDTH),
      .OFFSET_BITS (OFFSET_BITS)
   ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (entry_load),
      .clear     (entry_clear),
      .load_tag  (req_tag),
      .load_data (cache_wdata),
      .cmp_tag   (req_tag),
      .valid     (entry_valid),
      .addr      (entry_addr),
      .data      (entry_data),
      .match     (entry_match)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
      end
   end

   assign cache_rdata = rdata_q;

   // Strobes decode straight from state so an async reset drops them immediately.
   always_comb begin
      state_d      = state_q;
      rdata_d      = rdata_q;
      entry_load   = 1'b0;
      entry_clear  = 1'b0;
      cache_resp   = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      unique case (state_q)
         S_IDLE: begin
            if (cache_read) begin
`ifdef CACHE_WB_READ_FORWARD_EN
               if (entry_match) begin
                  rdata_d = entry_data;
                  state_d = S_RESP;
               end else begin
                  state_d = S_READ;
               end
`else
               // Flush the matching line first so pmem is coherent before the refill.
               state_d = entry_match ? S_DRAIN : S_READ;
`endif
            end else if (cache_write) begin
               if (!entry_valid || entry_match) begin
                  entry_load = 1'b1;
                  state_d    = S_RESP;
               end else begin
                  state_d = S_DRAIN;
               end
            end else if (entry_valid) begin
               state_d = S_DRAIN;
            end
         end
         S_RESP: begin
            cache_resp = 1'b1;
            state_d    = S_IDLE;
         end
         S_READ: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag, {OFFSET_BITS{1'b0}}};
            if (pmem_resp) begin
               rdata_d = pmem_rdata;
               state_d = S_RESP;
            end
         end
         S_DRAIN: begin
            pmem_write   = 1'b1;
            pmem_address = entry_addr;
            pmem_wdata   = entry_data;
            if (pmem_resp) begin
               entry_clear = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(cache_read && cache_write));
   pmem_strobe_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
      !(pmem_read && pmem_write));
   cache_resp_single: assert property (@(posedge clk) disable iff (!rst_n)
      cache_resp |=> !cache_resp);

endmodule

// File: tb/tb_cache_wb_buffer.sv
// Directed scoreboard bench for cache_wb_buffer with a fixed-latency pmem model.
module tb_cache_wb_buffer;

   localparam int PmemLat = 3;

   typedef struct {
      logic         wr;
      logic [15:0]  addr;
      logic [127:0] data;
   } pmem_op_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cache_read, cache_write;
   logic [15:0]  cache_address;
   logic [127:0] cache_wdata, cache_rdata;
   logic         cache_resp;
   logic         pmem_read, pmem_write;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_wdata, pmem_rdata;
   logic         pmem_resp;

   int checks = 0;
   int errors = 0;

   logic [127:0] cache_exp[$];
   pmem_op_t     pmem_exp[$];
   logic [127:0] mem[logic [11:0]];

   always #5 clk = ~clk;

   cache_wb_buffer u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .cache_read    (cache_read),
      .cache_write   (cache_write),
      .cache_address (cache_address),
      .cache_wdata   (cache_wdata),
      .cache_rdata   (cache_rdata),
      .cache_resp    (cache_resp),
      .pmem_read     (pmem_read),
      .pmem_write    (pmem_write),
      .pmem_address  (pmem_address),
      .pmem_wdata    (pmem_wdata),
      .pmem_rdata    (pmem_rdata),
      .pmem_resp     (pmem_resp)
   );

   function automatic logic [127:0] init_line(input logic [11:0] line);
      logic [15:0] w;
      w = {line, 4'h0} ^ 16'h5A5A;
      return {8{w}};
   endfunction

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   function automatic pmem_op_t mk_op(input logic wr, input logic [15:0] addr,
                                      input logic [127:0] data);
      pmem_op_t op;
      op.wr   = wr;
      op.addr = addr;
      op.data = data;
      return op;
   endfunction

   // pmem model: responds PmemLat cycles after a strobe appears, checks against the scoreboard.
   initial begin
      int cnt;
      pmem_op_t e;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      cnt = 0;
      forever begin
         @(negedge clk);
         pmem_resp = 1'b0;
         if (rst_n && (pmem_read || pmem_write)) begin
            cnt++;
            if (cnt == PmemLat) begin
               cnt = 0;
               pmem_resp = 1'b1;
               if (pmem_read) begin
                  pmem_rdata = mem.exists(pmem_address[15:4]) ? mem[pmem_address[15:4]]
                                                             : init_line(pmem_address[15:4]);
               end else begin
                  mem[pmem_address[15:4]] = pmem_wdata;
               end
               if (pmem_exp.size() == 0) begin
                  check("pmem_unexpected_op", {111'd0, pmem_write, pmem_address}, 128'd0);
               end else begin
                  e = pmem_exp.pop_front();
                  check("pmem_op_is_write", {127'd0, pmem_write}, {127'd0, e.wr});
                  check("pmem_op_addr", {112'd0, pmem_address}, {112'd0, e.addr});
                  if (e.wr) check("pmem_op_wdata", pmem_wdata, e.data);
               end
            end
         end else begin
            cnt = 0;
         end
      end
   end

   // Protocol monitor.
   initial begin
      logic prev_resp;
      prev_resp = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n) begin
            check("pmem_strobes_exclusive", {127'd0, pmem_read && pmem_write}, 128'd0);
            check("cache_resp_single", {127'd0, prev_resp && cache_resp}, 128'd0);
         end
         prev_resp = cache_resp;
      end
   end

   task automatic cache_req(input logic rd, input logic wr, input logic [15:0] addr,
                            input logic [127:0] data, output int cyc);
      logic found;
      cache_read    = rd;
      cache_write   = wr;
      cache_address = addr;
      cache_wdata   = data;
      found = 1'b0;
      cyc   = 0;
      for (int i = 1; i <= 80 && !found; i++) begin
         @(posedge clk);
         #1;
         if (cache_resp) begin
            found = 1'b1;
            cyc   = i;
         end
      end
      cache_read  = 1'b0;
      cache_write = 1'b0;
      check("cache_resp_seen", {127'd0, found}, 128'd1);
      if (found && rd) begin
         if (cache_exp.size() == 0) check("cache_unexpected_resp", cache_rdata, 128'd0);
         else check("cache_rdata", cache_rdata, cache_exp.pop_front());
      end
   endtask

   task automatic wait_quiet();
      logic done;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(posedge clk);
         #1;
         done = (pmem_exp.size() == 0) && !pmem_read && !pmem_write;
      end
      check("pmem_drained", {127'd0, done}, 128'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("quiet_no_pmem_write", {127'd0, pmem_write}, 128'd0);
      end
   endtask

   initial begin
      int cyc;
      logic seen;
      logic [127:0] a, b, c, d, d2;
      a  = {4{32'hAAAA_0001}};
      c  = {4{32'hCCCC_0003}};
      d  = {4{32'hDDDD_0004}};
      d2 = {4{32'hD2D2_0005}};
      b  = init_line(12'h200);

      rst_n = 1'b0;
      cache_read = 1'b0;
      cache_write = 1'b0;
      cache_address = '0;
      cache_wdata = '0;
      #12;
      check("rst_cache_resp", {127'd0, cache_resp}, 128'd0);
      check("rst_pmem_read", {127'd0, pmem_read}, 128'd0);
      check("rst_pmem_write", {127'd0, pmem_write}, 128'd0);
      check("rst_pmem_address", {112'd0, pmem_address}, 128'd0);
      check("rst_pmem_wdata", pmem_wdata, 128'd0);
      check("rst_cache_rdata", cache_rdata, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) begin
         @(posedge clk);
         #1;
         check("idle_strobes", {126'd0, pmem_read, pmem_write}, 128'd0);
         check("idle_cache_resp", {127'd0, cache_resp}, 128'd0);
      end

      // Write then idle: 1-cycle latency, drain starts on the following idle decision.
      pmem_exp.push_back(mk_op(1'b1, 16'h1230, a));
      cache_req(1'b0, 1'b1, 16'h1230, a, cyc);
      check("write_latency", 128'(cyc), 128'd1);
      @(posedge clk);
      #1;
      check("drain_not_yet", {127'd0, pmem_write}, 128'd0);
      @(posedge clk);
      #1;
      check("drain_started", {127'd0, pmem_write}, 128'd1);
      check("drain_addr", {112'd0, pmem_address}, 128'h1230);
      check("drain_wdata", pmem_wdata, a);
      wait_quiet();

      // Refill read overtakes the pending drain.
      pmem_exp.push_back(mk_op(1'b0, 16'h2000, '0));
      pmem_exp.push_back(mk_op(1'b1, 16'h1230, a));
      cache_exp.push_back(b);
      cache_req(1'b0, 1'b1, 16'h1230, a, cyc);
      cache_req(1'b1, 1'b0, 16'h2000, '0, cyc);
      wait_quiet();

      // Read hitting the held line.
`ifdef CACHE_WB_READ_FORWARD_EN
      pmem_exp.push_back(mk_op(1'b1, 16'h1230, a));
`else
      pmem_exp.push_back(mk_op(1'b1, 16'h1230, a));
      pmem_exp.push_back(mk_op(1'b0, 16'h1230, '0));
`endif
      cache_exp.push_back(a);
      cache_req(1'b0, 1'b1, 16'h1230, a, cyc);
      cache_req(1'b1, 1'b0, 16'h123E, '0, cyc);
`ifdef CACHE_WB_READ_FORWARD_EN
      check("forward_latency", 128'(cyc), 128'd2);
`endif
      wait_quiet();

      // Conflicting write forces a drain of A, then C is captured and later drained.
      pmem_exp.push_back(mk_op(1'b1, 16'h1230, a));
      pmem_exp.push_back(mk_op(1'b1, 16'h4560, c));
      cache_req(1'b0, 1'b1, 16'h1230, a, cyc);
      cache_req(1'b0, 1'b1, 16'h4560, c, cyc);
      check("conflict_write_drained_first", 128'(pmem_exp.size()), 128'd1);
      wait_quiet();

      // Coalescing write: only D reaches pmem.
      pmem_exp.push_back(mk_op(1'b1, 16'h1230, d));
      cache_req(1'b0, 1'b1, 16'h1230, a, cyc);
      cache_req(1'b0, 1'b1, 16'h1238, d, cyc);
      check("coalesce_latency", 128'(cyc), 128'd2);
      wait_quiet();

      // Reset in the middle of a drain.
      cache_req(1'b0, 1'b1, 16'h1230, d2, cyc);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(posedge clk);
         #1;
         seen = pmem_write;
      end
      check("reset_drain_started", {127'd0, seen}, 128'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("reset_async_pmem_write", {127'd0, pmem_write}, 128'd0);
      check("reset_async_pmem_address", {112'd0, pmem_address}, 128'd0);
      check("reset_async_pmem_wdata", pmem_wdata, 128'd0);
      check("reset_async_cache_rdata", cache_rdata, 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) begin
         @(posedge clk);
         #1;
         check("post_reset_no_drain", {126'd0, pmem_read, pmem_write}, 128'd0);
      end

      check("cache_scoreboard_empty", 128'(cache_exp.size()), 128'd0);
      check("pmem_scoreboard_empty", 128'(pmem_exp.size()), 128'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
